// File: rtl/gray_pkg.sv
// Shared constants and FSM state type for the Gray-code counter block.
package gray_pkg;

    localparam int WIDTH_DEFAULT = 4;

    // RUN encodes as 1 so the state flop doubles as the g_valid output.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bin_gray.sv
// Combinational binary-to-Gray conversion: each Gray bit is the XOR of adjacent binary bits.
module bin_gray #(
    parameter int WIDTH = gray_pkg::WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load, ready/valid back-pressure, terminal count and wrap pulse.
// The count is kept in binary; the Gray code is derived from the next binary value and registered alongside it.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g,
    output logic             g_valid,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;
    logic             acc;

    // A stalled valid code blocks everything; IDLE never stalls since nothing is presented yet.
    assign acc = (state_q == IDLE) | out_ready;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        tc_d    = tc_q;
        wrap_d  = 1'b0;
        if (acc) begin
            if (load) begin
                bin_d   = load_val;
                state_d = RUN;
            end else if (en) begin
                state_d = RUN;
                // The first enable out of IDLE only presents code 0.
                if (state_q == RUN) begin
                    if (up_dn) begin
                        bin_d  = bin_q + ONE;
                        wrap_d = &bin_q;
                    end else begin
                        bin_d  = bin_q - ONE;
                        wrap_d = ~|bin_q;
                    end
                end
            end
            tc_d = up_dn ? (&bin_d) : (~|bin_d);
        end
    end

    bin_gray #(
        .WIDTH(WIDTH)
    ) u_bin_gray (
        .bin_i (bin_d),
        .gray_o(g_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            g_q     <= '0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            g_q     <= g_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign g       = g_q;
    assign g_valid = (state_q == RUN);
    assign tc      = tc_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed vector table, hand-written stall/reset sequences,
// and a randomized run against an arithmetic reference model with a Gray-to-binary decoder.
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, up_dn, load, out_ready;
    logic [W-1:0] load_val;
    logic [W-1:0] g;
    logic         g_valid, tc, wrap;

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .out_ready(out_ready),
        .g        (g),
        .g_valid  (g_valid),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic         en;
        logic         up;
        logic         ld;
        logic [W-1:0] lv;
        logic         rdy;
        logic [W-1:0] g;
        logic         v;
        logic         tc;
        logic         wr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic u, input logic l, input int lv,
                                input logic r, input int eg, input logic ev, input logic et,
                                input logic ew);
        vec_t x;
        x.en = e; x.up = u; x.ld = l; x.lv = W'(lv); x.rdy = r;
        x.g = W'(eg); x.v = ev; x.tc = et; x.wr = ew;
        return x;
    endfunction

    // Standard prefix-XOR Gray decoder standing in for the downstream converter.
    function automatic int gray2bin(input logic [W-1:0] gc);
        logic [W-1:0] b;
        b[W-1] = gc[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ gc[i];
        return int'(b);
    endfunction

    task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lv,
                         input logic r);
        en = e; up_dn = u; load = l; load_val = lv; out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int eg, input int ev, input int et,
                             input int ew);
        check({tag, " g"}, int'(g), eg);
        check({tag, " g_valid"}, int'(g_valid), ev);
        check({tag, " tc"}, int'(tc), et);
        check({tag, " wrap"}, int'(wrap), ew);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Reference model state: the count as a plain integer modulo 2^W.
    int m_bin;
    bit m_valid, m_tc, m_wrap;

    task automatic model_step(input bit e, input bit u, input bit l, input int lv, input bit r,
                              output bit stepped);
        bit acc;
        acc     = !m_valid || r;
        stepped = 0;
        m_wrap  = 0;
        if (acc) begin
            if (l) begin
                m_bin   = lv;
                m_valid = 1;
            end else if (e) begin
                if (m_valid) begin
                    stepped = 1;
                    if (u) begin
                        m_wrap = (m_bin == MOD - 1);
                        m_bin  = (m_bin + 1) % MOD;
                    end else begin
                        m_wrap = (m_bin == 0);
                        m_bin  = (m_bin + MOD - 1) % MOD;
                    end
                end
                m_valid = 1;
            end
            m_tc = u ? (m_bin == MOD - 1) : (m_bin == 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Directed vectors: up count through a full cycle and its wrap, load 5, then count down
        // through zero.
        tbl.push_back(mk(1,1,0,0,1,  0, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  1, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  3, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  2, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  6, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  7, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  5, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  4, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1, 12, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1, 13, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1, 15, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1, 14, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1, 10, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1, 11, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  9, 1,0,0));
        tbl.push_back(mk(1,1,0,0,1,  8, 1,1,0));
        tbl.push_back(mk(1,1,0,0,1,  0, 1,0,1));
        tbl.push_back(mk(1,1,1,5,1,  7, 1,0,0));
        tbl.push_back(mk(1,0,0,0,1,  6, 1,0,0));
        tbl.push_back(mk(1,0,0,0,1,  2, 1,0,0));
        tbl.push_back(mk(1,0,0,0,1,  3, 1,0,0));
        tbl.push_back(mk(1,0,0,0,1,  1, 1,0,0));
        tbl.push_back(mk(1,0,0,0,1,  0, 1,1,0));
        tbl.push_back(mk(1,0,0,0,1,  8, 1,0,1));
        tbl.push_back(mk(0,0,0,0,1,  8, 1,0,0));

        repeat (2) tick();
        rst = 1'b0;
        check_out("reset", 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lv, tbl[i].rdy);
            tick();
            check_out($sformatf("row%0d", i), int'(tbl[i].g), int'(tbl[i].v), int'(tbl[i].tc),
                      int'(tbl[i].wr));
        end

        // Back-pressure: stalled code holds for 4 cycles, a load during the stall is dropped,
        // then stepping resumes from the held value (bin 15 up -> 0 with wrap).
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
            tick();
            check_out($sformatf("stall%0d", i), 8, 1, 0, 0);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        tick();
        check_out("stall_load", 8, 1, 0, 0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        tick();
        check_out("resume", 0, 1, 0, 1);
        tick();
        check_out("resume2", 1, 1, 0, 0);
        tick();
        check_out("resume3", 3, 1, 0, 0);

        // Asynchronous reset between edges takes effect before the next edge.
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        tick();
        check_out("rst_held", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_out("post_rst_first", 0, 1, 0, 0);
        tick();
        check_out("post_rst_second", 1, 1, 0, 0);

        // Randomized run against the reference model and the Gray decoder.
        do_reset();
        m_bin = 0; m_valid = 0; m_tc = 0; m_wrap = 0;
        for (int c = 0; c < 1000; c++) begin
            bit e, u, l, r, stepped;
            int lv;
            logic [W-1:0] prev_g;
            e  = 1'($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 15) == 0);
            r  = 1'($urandom_range(0, 3) != 0);
            lv = int'($urandom_range(0, MOD - 1));
            prev_g = g;
            drive(e, u, l, W'(lv), r);
            model_step(e, u, l, lv, r, stepped);
            tick();
            check($sformatf("rnd%0d g_valid", c), int'(g_valid), int'(m_valid));
            check($sformatf("rnd%0d decoded", c), gray2bin(g), m_bin);
            check($sformatf("rnd%0d tc", c), int'(tc), int'(m_tc));
            check($sformatf("rnd%0d wrap", c), int'(wrap), int'(m_wrap));
            if (stepped)
                check($sformatf("rnd%0d onebit", c), $countones(g ^ prev_g), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
